ddio_out_serdes: RTL and testbench

DDIO_OUT_SERDES -- requirements
Module: ddio_out_serdes

---
 rtl/ddio_pkg.sv | 27 ++
 rtl/ddio_out_lane.sv | 75 +++++++
 rtl/ddio_out_serdes.sv | 142 ++++++++++++++
 tb/tb_ddio_out_serdes.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddio_pkg.sv
// Shared types and elaboration helpers for the DDR output serializer.
package ddio_pkg;

    // Shifter occupancy: IDLE drives the idle level, ACTIVE plays a word.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Width of the phase counter that walks RATIO/2 bit pairs (at least 1 bit).
    function automatic int phase_width(input int ratio);
        int w;
        w = $clog2(ratio / 2);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal channel count.
    function automatic bit width_ok(input int width);
        return (width >= 1) && (width <= 64);
    endfunction

    // Legal serialization ratio: even, 2..16.
    function automatic bit ratio_ok(input int ratio);
        return (ratio >= 2) && (ratio <= 16) && ((ratio % 2) == 0);
    endfunction

endpackage

// File: rtl/ddio_out_lane.sv
// One DDR output channel: word shifter, rising-edge h/l pair registers,
// falling-edge retime of the low half and the clock-phase output mux.
module ddio_out_lane #(
    parameter int   RATIO      = 8,
    parameter int   PW         = 2,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   INVERT     = 1'b0
) (
    input  logic             outclock_i,
    input  logic             aclr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             idle_i,
    input  logic             oe_i,
    input  logic [RATIO-1:0] load_data_i,
    input  logic [PW-1:0]    p_d_i,
    output logic             dataout_o
);

    localparam int IW = $clog2(RATIO);

    logic [RATIO-1:0] sh_q, sh_d;
    logic             h_q, h_d;
    logic             l_q, l_d;
    logic             l_neg_q;
    logic [RATIO-1:0] src;
    logic [IW-1:0]    idx_h, idx_l;

    // Pick the next bit pair: a freshly loaded word starts at pair 0 straight
    // from the load bus so the first pair appears without an extra cycle.
    always_comb begin
        sh_d  = sh_q;
        h_d   = h_q;
        l_d   = l_q;
        src   = load_i ? load_data_i : sh_q;
        idx_h = IW'({p_d_i, 1'b0});
        idx_l = idx_h + IW'(1);
        if (idle_i) begin
            h_d = IDLE_LEVEL;
            l_d = IDLE_LEVEL;
        end else if (load_i || step_i) begin
            h_d = oe_i ? (src[idx_h] ^ INVERT) : IDLE_LEVEL;
            l_d = oe_i ? (src[idx_l] ^ INVERT) : IDLE_LEVEL;
            if (load_i) begin
                sh_d = load_data_i;
            end
        end
    end

    // Rising-edge shifter and pair registers.
    always_ff @(posedge outclock_i or posedge aclr_i) begin
        if (aclr_i) begin
            sh_q <= '0;
            h_q  <= IDLE_LEVEL;
            l_q  <= IDLE_LEVEL;
        end else begin
            sh_q <= sh_d;
            h_q  <= h_d;
            l_q  <= l_d;
        end
    end

    // Retime the low half onto the falling edge so the mux never sees it change
    // while the low phase is selected.
    always_ff @(negedge outclock_i or posedge aclr_i) begin
        if (aclr_i) begin
            l_neg_q <= IDLE_LEVEL;
        end else begin
            l_neg_q <= l_q;
        end
    end

    assign dataout_o = outclock_i ? h_q : l_neg_q;

endmodule

// File: rtl/ddio_out_serdes.sv
// Parallel-to-DDR serializer: one-entry holding register with valid/ready
// intake, shared phase counter and OE/underflow control, WIDTH output lanes.
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready does not depend on in_valid and is low during sclr or aclr.
module ddio_out_serdes
    import ddio_pkg::*;
#(
    parameter int    WIDTH             = 4,
    parameter int    RATIO             = 8,
    parameter logic  IDLE_LEVEL        = 1'b0,
    parameter string INVERT_OUTPUT     = "OFF",
    parameter string EXTEND_OE_DISABLE = "OFF"
) (
    input  logic                   outclock,
    input  logic                   aclr,
    input  logic                   sclr,
    input  logic [WIDTH*RATIO-1:0] in_data,
    input  logic                   in_oe,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       dataout,
    output logic [WIDTH-1:0]       oe_out,
    output logic                   underflow,
    output state_e                 dbg_state_o
);

    localparam int          PAIRS  = RATIO / 2;
    localparam int          PW     = phase_width(RATIO);
    localparam logic [PW-1:0] P_LAST = PW'(PAIRS - 1);
    localparam bit          INV    = (INVERT_OUTPUT == "ON");
    localparam bit          EXT    = (EXTEND_OE_DISABLE == "ON");

    if (!width_ok(WIDTH) || !ratio_ok(RATIO)) begin : g_bad_params
        $error("ddio_out_serdes: WIDTH must be 1..64 and RATIO even 2..16");
    end

    state_e                 state_q, state_d;
    logic [PW-1:0]          p_q, p_d;
    logic                   hold_full_q, hold_full_d;
    logic [WIDTH*RATIO-1:0] hold_data_q;
    logic                   hold_oe_q;
    logic                   oe_q, oe_d;
    logic                   oe_prev_q;
    logic                   uf_q, uf_d;
    logic                   rdy_q;
    logic                   load, step, go_idle, accept, lane_oe;

    // The shifter takes the held word when idle or when its last pair is on the pins.
    assign load     = hold_full_q && ((state_q == IDLE) || (p_q == P_LAST));
    assign in_ready = rdy_q && !sclr && (!hold_full_q || load);
    assign accept   = in_valid && in_ready;
    assign lane_oe  = load ? hold_oe_q : oe_q;

    // Next-state: sclr abort, word load, starvation to idle, or pair advance.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        hold_full_d = hold_full_q;
        oe_d        = oe_q;
        uf_d        = 1'b0;
        step        = 1'b0;
        go_idle     = 1'b0;
        if (sclr) begin
            state_d     = IDLE;
            p_d         = '0;
            hold_full_d = 1'b0;
            oe_d        = 1'b0;
            go_idle     = 1'b1;
        end else begin
            if (load) begin
                state_d     = ACTIVE;
                p_d         = '0;
                oe_d        = hold_oe_q;
                hold_full_d = 1'b0;
            end else if ((state_q == ACTIVE) && (p_q == P_LAST)) begin
                state_d = IDLE;
                p_d     = '0;
                oe_d    = 1'b0;
                uf_d    = 1'b1;
                go_idle = 1'b1;
            end else if (state_q == ACTIVE) begin
                p_d  = p_q + 1'b1;
                step = 1'b1;
            end
            if (accept) begin
                hold_full_d = 1'b1;
            end
        end
    end

    // Control state registers; rdy_q keeps in_ready low until the first edge after aclr.
    always_ff @(posedge outclock or posedge aclr) begin
        if (aclr) begin
            state_q     <= IDLE;
            p_q         <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_oe_q   <= 1'b0;
            oe_q        <= 1'b0;
            oe_prev_q   <= 1'b0;
            uf_q        <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            hold_full_q <= hold_full_d;
            oe_q        <= oe_d;
            oe_prev_q   <= sclr ? 1'b0 : oe_q;
            uf_q        <= uf_d;
            rdy_q       <= 1'b1;
            if (accept) begin
                hold_data_q <= in_data;
                hold_oe_q   <= in_oe;
            end
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_lane
        ddio_out_lane #(
            .RATIO     (RATIO),
            .PW        (PW),
            .IDLE_LEVEL(IDLE_LEVEL),
            .INVERT    (INV)
        ) u_lane (
            .outclock_i (outclock),
            .aclr_i     (aclr),
            .load_i     (load),
            .step_i     (step),
            .idle_i     (go_idle),
            .oe_i       (lane_oe),
            .load_data_i(hold_data_q[c*RATIO +: RATIO]),
            .p_d_i      (p_d),
            .dataout_o  (dataout[c])
        );
    end

    // A falling OE is held one extra cycle when extension is enabled.
    assign oe_out      = {WIDTH{oe_q | (EXT & oe_prev_q)}};
    assign underflow   = uf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ddio_out_serdes.sv
// Self-checking bench: three configurations driven by one stimulus stream,
// a pair-level reference model filling an expected queue, and a monitor.
module tb_ddio_out_serdes;
    import ddio_pkg::*;

    localparam int W     = 2;
    localparam int R     = 4;
    localparam int PAIRS = R / 2;
    localparam int DW    = W * R;
    localparam int EW    = 11;

    logic          outclock = 1'b0;
    logic          aclr, sclr, in_oe, in_valid;
    logic [DW-1:0] in_data;

    logic          rdy_m, rdy_e, rdy_i;
    logic [W-1:0]  dout_m, dout_e, dout_i;
    logic [W-1:0]  oe_m, oe_e, oe_i;
    logic          uf_m, uf_e, uf_i;
    state_e        st_m, st_e, st_i;

    int checks = 0;
    int errors = 0;

    ddio_out_serdes #(.WIDTH(W), .RATIO(R)) u_dut (
        .outclock(outclock), .aclr(aclr), .sclr(sclr), .in_data(in_data),
        .in_oe(in_oe), .in_valid(in_valid), .in_ready(rdy_m), .dataout(dout_m),
        .oe_out(oe_m), .underflow(uf_m), .dbg_state_o(st_m));

    ddio_out_serdes #(.WIDTH(W), .RATIO(R), .EXTEND_OE_DISABLE("ON")) u_ext (
        .outclock(outclock), .aclr(aclr), .sclr(sclr), .in_data(in_data),
        .in_oe(in_oe), .in_valid(in_valid), .in_ready(rdy_e), .dataout(dout_e),
        .oe_out(oe_e), .underflow(uf_e), .dbg_state_o(st_e));

    ddio_out_serdes #(.WIDTH(W), .RATIO(R), .IDLE_LEVEL(1'b1), .INVERT_OUTPUT("ON")) u_inv (
        .outclock(outclock), .aclr(aclr), .sclr(sclr), .in_data(in_data),
        .in_oe(in_oe), .in_valid(in_valid), .in_ready(rdy_i), .dataout(dout_i),
        .oe_out(oe_i), .underflow(uf_i), .dbg_state_o(st_i));

    // clock / reset
    always #5 outclock = ~outclock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state (word and pair level)
    logic [DW:0]   hold_q[$];   // {oe, word} accepted, not yet started
    logic [4:0]    cur_q[$];    // {oe, h[1:0], l[1:0]} pairs still to play
    logic [EW-1:0] exp_q[$];    // {uf, oe_ext, oe, inv_h, inv_l, h, l} per cycle
    bit            rdy_en;
    bit            rdy_base;

    // model: one expected record per rising edge outside reset
    initial begin : model
        bit            was_active, prev_oe, acc, uf, oe, oex;
        logic [4:0]    disp, pr;
        logic [DW:0]   wd;
        logic [EW-1:0] rec;
        logic [1:0]    mh, ml, ih, il;
        rdy_en = 0; rdy_base = 0; was_active = 0; prev_oe = 0;
        forever begin
            @(posedge outclock);
            if (aclr) begin
                hold_q.delete(); cur_q.delete();
                rdy_en = 0; rdy_base = 0; was_active = 0; prev_oe = 0;
            end else begin
                acc = in_valid && !sclr && rdy_en && (hold_q.size() == 0 || cur_q.size() == 0);
                uf = 0; oex = 0; disp = '0;
                if (sclr) begin
                    hold_q.delete(); cur_q.delete();
                    was_active = 0;
                end else begin
                    if (cur_q.size() == 0 && hold_q.size() > 0) begin
                        wd = hold_q.pop_front();
                        for (int k = 0; k < PAIRS; k++) begin
                            pr = '0;
                            pr[4] = wd[DW];
                            for (int c = 0; c < W; c++) begin
                                pr[2 + c] = wd[c*R + 2*k];
                                pr[c]     = wd[c*R + 2*k + 1];
                            end
                            cur_q.push_back(pr);
                        end
                    end
                    if (cur_q.size() > 0) begin
                        disp = cur_q.pop_front();
                        was_active = 1;
                    end else begin
                        uf = was_active;
                        was_active = 0;
                    end
                    if (acc) hold_q.push_back({in_oe, in_data});
                end
                oe = disp[4];
                if (!sclr) oex = oe | prev_oe;
                prev_oe = oe;
                mh = oe ? disp[3:2] : 2'b00;
                ml = oe ? disp[1:0] : 2'b00;
                ih = oe ? ~disp[3:2] : 2'b11;
                il = oe ? ~disp[1:0] : 2'b11;
                rec = {uf, oex, oe, ih, il, mh, ml};
                exp_q.push_back(rec);
                rdy_en = 1;
                rdy_base = (hold_q.size() == 0 || cur_q.size() == 0);
            end
        end
    end

    // monitor: pops one record per cycle, checks both half-cycles and in_ready
    initial begin : monitor
        logic [EW-1:0] rec;
        bit have;
        forever begin
            @(posedge outclock); #1;
            have = 0;
            if (!aclr) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: no expected record at %0t", $time);
                end else begin
                    rec = exp_q.pop_front();
                    have = 1;
                    chk("dataout_h", dout_m, rec[3:2]);
                    chk("oe_out", oe_m, {2{rec[8]}});
                    chk("underflow", uf_m, rec[10]);
                    chk("ext_dataout_h", dout_e, rec[3:2]);
                    chk("ext_oe_out", oe_e, {2{rec[9]}});
                    chk("inv_dataout_h", dout_i, rec[7:6]);
                    chk("inv_oe_out", oe_i, {2{rec[8]}});
                end
            end
            @(negedge outclock); #1;
            if (!aclr && have) begin
                chk("dataout_l", dout_m, rec[1:0]);
                chk("inv_dataout_l", dout_i, rec[5:4]);
            end
            #1;
            if (!aclr) chk("in_ready", rdy_m, rdy_en && !sclr && rdy_base);
        end
    end

    // driver tasks
    task automatic send_word(input logic [DW-1:0] d, input logic o);
        bit done;
        int t;
        done = 0; t = 0;
        while (!done) begin
            @(negedge outclock);
            in_valid = 1; in_data = d; in_oe = o;
            #3;
            done = rdy_m;
            @(posedge outclock);
            t++;
            if (!done && t > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
                done = 1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge outclock);
            in_valid = 0; sclr = 0;
        end
    endtask

    initial begin : stimulus
        aclr = 0; sclr = 0; in_valid = 0; in_oe = 0; in_data = '0;
        #1 aclr = 1;
        #2;
        chk("reset_dataout", dout_m, 2'b00);
        chk("reset_oe_out", oe_m, 2'b00);
        chk("reset_underflow", uf_m, 1'b0);
        chk("reset_in_ready", rdy_m, 1'b0);
        chk("reset_inv_dataout", dout_i, 2'b11);
        @(negedge outclock); #3 aclr = 0;

        idle_cycles(2);
        send_word(8'hA5, 1'b1);                     // single word
        idle_cycles(6);
        send_word(8'h3C, 1'b1);                     // three back-to-back words
        send_word(8'h96, 1'b1);
        send_word(8'hE1, 1'b0);
        idle_cycles(6);
        send_word(8'hFF, 1'b1);                     // sclr aborts mid-word
        @(negedge outclock); in_valid = 0;
        @(negedge outclock); sclr = 1;
        @(negedge outclock); sclr = 0;
        send_word(8'h0F, 1'b1);
        idle_cycles(6);
        send_word(8'h00, 1'b1);                     // inverted all-zero word
        idle_cycles(5);

        repeat (400) begin                          // random stream
            @(negedge outclock);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            in_oe    = ($urandom_range(0, 4) != 0);
            sclr     = ($urandom_range(0, 40) == 0);
        end
        idle_cycles(6);

        send_word(8'h5A, 1'b1);                     // aclr mid-word
        @(negedge outclock); in_valid = 0;
        @(posedge outclock); #2 aclr = 1;
        #1;
        chk("aclr_dataout", dout_m, 2'b00);
        chk("aclr_oe_out", oe_m, 2'b00);
        chk("aclr_in_ready", rdy_m, 1'b0);
        chk("aclr_inv_dataout", dout_i, 2'b11);
        chk("aclr_ext_oe_out", oe_e, 2'b00);
        @(posedge outclock);
        @(negedge outclock); #3 aclr = 0;
        idle_cycles(3);
        send_word(8'hC3, 1'b1);
        idle_cycles(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
